// File: rtl/product_spi_tx_ctrl.sv
// SPI mode-0 transmitter for the 64-bit multiplier product.
// Selects the MSB word, then the LSB word, through the external mux and
// shifts both out MSB first as one continuous cs_n-framed 2*WORD_W-bit frame.
module product_spi_tx_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [WORD_W-1:0] mux_out,
  output logic              clk_sel,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  output logic              busy,
  output logic              done
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_MSB, SHIFT_MSB, LOAD_LSB, SHIFT_LSB, DONE
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] sh;

  // mosi is the shift register MSB: a flop output, so it cannot glitch,
  // and clearing the register drives the idle level.
  assign mosi = sh[WORD_W-1];

  // Frame sequencer: one FSM owns the divider, bit counter, shifter and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div         <= '0;
      bit_cnt     <= '0;
      sh          <= '0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      cs_n        <= 1'b1;
      sclk        <= 1'b0;
      clk_sel     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            state       <= LOAD_MSB;
            start_ready <= 1'b0;
            busy        <= 1'b1;
          end
        end
        // Load cycles: mux already points at the right word
        LOAD_MSB, LOAD_LSB: begin
          sh      <= mux_out;
          cs_n    <= 1'b0;
          sclk    <= 1'b0;
          div     <= '0;
          bit_cnt <= '0;
          state   <= (state == LOAD_MSB) ? SHIFT_MSB : SHIFT_LSB;
        end
        SHIFT_MSB, SHIFT_LSB: begin
          if (div == DIV_LAST) begin
            div  <= '0;
            sclk <= ~sclk;
            // High->low edge closes a bit slot
            if (sclk) begin
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                if (state == SHIFT_MSB) begin
                  clk_sel <= 1'b1;
                  state   <= LOAD_LSB;
                end else begin
                  done  <= 1'b1;
                  state <= DONE;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                sh      <= {sh[WORD_W-2:0], 1'b0};
              end
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        // Frame closes on DONE exit so cs_n is high only in DONE->IDLE->LOAD
        DONE: begin
          done        <= 1'b0;
          cs_n        <= 1'b1;
          sh          <= '0;
          clk_sel     <= 1'b0;
          start_ready <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_product_spi_tx_ctrl.sv
// Bench for product_spi_tx_ctrl: a mode-0 slave model recovers frames from
// sclk rising edges and compares them with the product words sent.
module tb_product_spi_tx_ctrl;
  localparam int W  = 32;
  localparam int D0 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // DUT0: default divider
  logic sv0 = 1'b0, sr0, sel0, sclk0, cs0, mosi0, busy0, done0;
  logic [W-1:0] msb0 = '0, lsb0 = '0, mux0;
  assign mux0 = sel0 ? lsb0 : msb0;

  product_spi_tx_ctrl #(.CLK_DIV(D0), .WORD_W(W)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv0), .start_ready(sr0),
    .mux_out(mux0), .clk_sel(sel0), .sclk(sclk0), .cs_n(cs0), .mosi(mosi0),
    .busy(busy0), .done(done0));

  // DUT1: divider of one
  logic sv1 = 1'b0, sr1, sel1, sclk1, cs1, mosi1, busy1, done1;
  logic [W-1:0] msb1 = '0, lsb1 = '0, mux1;
  assign mux1 = sel1 ? lsb1 : msb1;

  product_spi_tx_ctrl #(.CLK_DIV(1), .WORD_W(W)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
    .mux_out(mux1), .clk_sel(sel1), .sclk(sclk1), .cs_n(cs1), .mosi(mosi1),
    .busy(busy1), .done(done1));

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model for DUT0
  logic p_sclk0 = 1'b0, p_mosi0 = 1'b0;
  logic rx0[$];
  int   ecyc0[$];
  int   done_n0 = 0, done_at0 = -1, sel_bad0 = 0, mosi_bad0 = 0, inv_bad0 = 0;
  int   gap0 = 0, hi_run0 = 0, fidx0 = 0;
  always @(negedge clk) begin
    if (cs0 === 1'b1) fidx0 = 0;
    if (sclk0 && !p_sclk0) begin
      rx0.push_back(mosi0);
      ecyc0.push_back(cyc);
      if (sel0 !== (fidx0 >= W)) sel_bad0++;
      fidx0++;
    end
    if (sclk0 && (mosi0 !== p_mosi0)) mosi_bad0++;
    if (done0) begin done_n0++; done_at0 = cyc; end
    if (busy0 === sr0) inv_bad0++;
    if (cs0) hi_run0++;
    else begin
      if (hi_run0 > 0) gap0 = hi_run0;
      hi_run0 = 0;
    end
    p_sclk0 = sclk0;
    p_mosi0 = mosi0;
  end

  // Slave model for DUT1
  logic p_sclk1 = 1'b0;
  logic rx1[$];
  int   ecyc1[$];
  int   done_n1 = 0, done_at1 = -1;
  always @(negedge clk) begin
    if (sclk1 && !p_sclk1) begin
      rx1.push_back(mosi1);
      ecyc1.push_back(cyc);
    end
    if (done1) begin done_n1++; done_at1 = cyc; end
    p_sclk1 = sclk1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] get64(input int b, input bit which);
    logic [63:0] v = '0;
    for (int i = 0; i < 64; i++) v = {v[62:0], which ? rx1[b+i] : rx0[b+i]};
    return v;
  endfunction

  // {start_ready, busy, done, cs_n, sclk, mosi, clk_sel}
  localparam logic [6:0] RST_OUT = 7'b1001000;
  function automatic logic [6:0] outs0();
    return {sr0, busy0, done0, cs0, sclk0, mosi0, sel0};
  endfunction
  function automatic logic [6:0] outs1();
    return {sr1, busy1, done1, cs1, sclk1, mosi1, sel1};
  endfunction

  task automatic accept0(input bit hold, output int t0, output int base);
    int n = 0;
    while (!sr0 && n < 2000) begin @(posedge clk); #1; n++; end
    if (!sr0) chk("ready_timeout", 0, 1);
    sv0 = 1'b1;
    @(posedge clk); #1;
    if (!hold) sv0 = 1'b0;
    t0   = cyc;
    base = rx0.size();
  endtask

  task automatic wait_done0(input int target);
    int n = 0;
    while (done_n0 < target && n < 3000) begin @(posedge clk); #1; n++; end
    if (done_n0 < target) chk("done_timeout", 0, 1);
    // One cycle after DONE: back to idle levels
    chk("post_done_outs", {sr0, busy0, cs0, mosi0, sel0}, 5'b10100);
  endtask

  task automatic check_frame0(input string nm, input int t0, input int base, input logic [63:0] exp);
    chk({nm, "_edges"}, rx0.size() - base, 64);
    chk({nm, "_data"}, get64(base, 1'b0), exp);
    chk({nm, "_done_cycle"}, done_at0 - t0 + 1, 3 + 4 * W * D0);
    chk({nm, "_first_rise"}, ecyc0[base] - t0, 1 + D0);
    chk({nm, "_lsb_gap"}, ecyc0[base+W] - ecyc0[base+W-1], 2 * D0 + 1);
  endtask

  typedef struct {
    string       name;
    logic [31:0] msb;
    logic [31:0] lsb;
    logic [63:0] exp;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int t0, base, t1, base1, dn, n, bad;
    logic [31:0] rm, rl;

    tbl[0] = '{"deadbeef", 32'hDEADBEEF, 32'h01234567, 64'hDEADBEEF01234567};
    tbl[1] = '{"zeros",    32'h00000000, 32'h00000000, 64'h0000000000000000};
    tbl[2] = '{"ones",     32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    tbl[3] = '{"edges",    32'h80000001, 32'hAAAAAAAA, 64'h80000001AAAAAAAA};

    // Reset held for 3 cycles, outputs static at reset values
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_outs0", outs0(), RST_OUT);
    end
    chk("reset_outs1", outs1(), RST_OUT);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table of single frames
    for (int i = 0; i < 4; i++) begin
      msb0 = tbl[i].msb;
      lsb0 = tbl[i].lsb;
      accept0(1'b0, t0, base);
      wait_done0(done_n0 + 1);
      check_frame0(tbl[i].name, t0, base, tbl[i].exp);
    end

    // Back-to-back with start_valid held
    msb0 = 32'hCAFEF00D; lsb0 = 32'h13579BDF;
    dn = done_n0;
    accept0(1'b1, t0, base);
    wait_done0(dn + 1);
    @(posedge clk); #1;
    chk("b2b_second_accept", busy0, 1'b1);
    sv0   = 1'b0;
    t1    = cyc;
    base1 = base + 64;
    wait_done0(dn + 2);
    chk("b2b_first_data", get64(base, 1'b0), 64'hCAFEF00D13579BDF);
    check_frame0("b2b_second", t1, base1, 64'hCAFEF00D13579BDF);
    chk("b2b_cs_gap", gap0, 2);

    // Start pulses every 7 cycles mid-frame are ignored
    msb0 = 32'h0F1E2D3C; lsb0 = 32'h4B5A6978;
    dn = done_n0;
    accept0(1'b0, t0, base);
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      repeat (6) @(posedge clk);
      #1 sv0 = 1'b1;
      if (sr0 !== 1'b0) bad++;
      @(posedge clk); #1 sv0 = 1'b0;
    end
    chk("ign_ready_low", bad, 0);
    wait_done0(dn + 1);
    check_frame0("ignored", t0, base, 64'h0F1E2D3C4B5A6978);
    repeat (20) @(posedge clk);
    #1;
    chk("ign_single_done", done_n0 - dn, 1);
    chk("ign_idle", busy0, 1'b0);

    // Reset after the 40th rising edge
    msb0 = 32'h12345678; lsb0 = 32'h9ABCDEF0;
    accept0(1'b0, t0, base);
    n = 0;
    while (rx0.size() - base < 40 && n < 2000) begin @(posedge clk); #1; n++; end
    if (rx0.size() - base < 40) chk("rst_edge_timeout", 0, 1);
    dn = done_n0;
    #2 rst_n = 1'b0;
    #1 chk("rst_async_outs", outs0(), RST_OUT);
    repeat (3) @(posedge clk);
    #1 chk("rst_held_outs", outs0(), RST_OUT);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("rst_no_done", done_n0 - dn, 0);
    msb0 = 32'h00000001; lsb0 = 32'h00000002;
    accept0(1'b0, t0, base);
    wait_done0(done_n0 + 1);
    check_frame0("after_rst", t0, base, 64'h0000000100000002);

    // Randomised frames against the {msb,lsb} reference
    for (int r = 0; r < 5; r++) begin
      rm = $urandom; rl = $urandom;
      msb0 = rm; lsb0 = rl;
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      accept0(1'b0, t0, base);
      wait_done0(done_n0 + 1);
      check_frame0("random", t0, base, {rm, rl});
    end

    chk("sel_per_word", sel_bad0, 0);
    chk("mosi_stable_high", mosi_bad0, 0);
    chk("busy_vs_ready", inv_bad0, 0);

    // CLK_DIV = 1 corner
    msb1 = 32'hFFFFFFFF; lsb1 = 32'h00000000;
    sv1 = 1'b1;
    @(posedge clk); #1;
    sv1 = 1'b0;
    t0 = cyc;
    base = rx1.size();
    n = 0;
    while (done_n1 < 1 && n < 500) begin @(posedge clk); #1; n++; end
    if (done_n1 < 1) chk("div1_done_timeout", 0, 1);
    chk("div1_edges", rx1.size() - base, 64);
    chk("div1_data", get64(base, 1'b1), 64'hFFFFFFFF00000000);
    chk("div1_frame_len", done_at1 - t0 + 1, 131);
    chk("div1_first_rise", ecyc1[base] - t0, 2);
    bad = 0;
    for (int i = 0; i < 63; i++)
      if (ecyc1[base+i+1] - ecyc1[base+i] != ((i == W - 1) ? 3 : 2)) bad++;
    chk("div1_period", bad, 0);
    chk("div1_idle", {sr1, cs1}, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_spi_tx_ctrl.md
# product_spi_tx_ctrl

- Sequences the serial read-out of the 64-bit multiplier product over an SPI-mode-0 link (CPOL = 0, CPHA = 0).
- Drives the select of the 32-bit product MSB/LSB word multiplexer and loads the selected word from the mux output.
- Shifts the frame out MSB word first, MSB bit first.
- Generates `sclk`, `cs_n` and `mosi` from the system clock, and handshakes frame start/completion with the multiplier datapath.

## Interface
Parameters:
- `CLK_DIV`, default 4: system-clock cycles per `sclk` half-period; legal range is ≥ 1.
- `WORD_W`, default 32: width of each product word; the frame is 2·WORD_W bits.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `start_valid`  in  1  product ready for transmission.
- `start_ready`  out  1  controller idle, accepts a start request.
- `mux_out`  in  WORD_W  word from the MSB/LSB mux.
- `clk_sel`  out  1  mux select: 0 = product_MSB, 1 = product_LSB.
- `sclk`  out  1  serial clock; idles low.
- `cs_n`  out  1  active-low chip select, framing all 64 bits.
- `mosi`  out  1  serial data.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse at frame end.

## Operation
- **States:** IDLE → LOAD_MSB → SHIFT_MSB → LOAD_LSB → SHIFT_LSB → DONE → IDLE.
- **Reset values** (also the outputs throughout IDLE): `start_ready`=1, `busy`=0, `done`=0, `cs_n`=1, `sclk`=0, `mosi`=0, `clk_sel`=0; internal counters = 0.
- **IDLE:** on `start_valid && start_ready`, go to LOAD_MSB.
  - Upstream holds product_MSB/product_LSB stable from acceptance until `done`.
- **LOAD_MSB** (1 cycle):
  - `clk_sel`=0.
  - On exit: shift register ← `mux_out`, `cs_n` ← 0, `mosi` ← `mux_out[WORD_W-1]`.
- **SHIFT_MSB:** WORD_W bit slots, each 2·CLK_DIV cycles.
  - First half of each slot: `sclk` low for CLK_DIV cycles.
  - Second half: `sclk` high for CLK_DIV cycles.
  - At each high→low transition the register shifts left and `mosi` presents the next bit.
  - After slot WORD_W−1, `sclk` returns low, `clk_sel` ← 1 and the state goes to LOAD_LSB.
- **LOAD_LSB** (1 cycle):
  - `clk_sel`=1, so `mux_out` now carries the LSB word.
  - On exit: shift register ← `mux_out`, `mosi` ← its MSB.
  - `cs_n` stays low: one continuous 64-bit frame.
- **SHIFT_LSB:** same slot timing as SHIFT_MSB; after the last slot go to DONE.
- **DONE** (1 cycle): `cs_n` ← 1, `mosi` ← 0, `clk_sel` ← 0, `done`=1, `start_ready`=0. Then go to IDLE.
- **`busy`:** high in every non-IDLE state. `start_ready` = (state == IDLE).
- **Start requests while not IDLE:** ignored; nothing is queued.
- **Counters:**
  - Bit counter: $clog2(WORD_W) bits, wraps per word.
  - Divider: $clog2(CLK_DIV)+1 bits, or 1 bit when CLK_DIV = 1.
- **Reset mid-frame:** all outputs return asynchronously to reset values, with no `done` pulse and no partial completion. The next accepted frame starts clean.

## Timing
- Acceptance edge = T0. LOAD_MSB occupies cycle 1.
- `cs_n` falls and bit 63 appears on `mosi` at the end of cycle 1.
- First `sclk` rising edge: CLK_DIV cycles after `cs_n` falls.
- `mosi` changes only on `sclk` falling edges, or at LOAD exits while `sclk` is low. It is stable across every rising edge.
- Low time before the first LSB rising edge is CLK_DIV+1 cycles, because LOAD_LSB inserts one cycle.
- Frame duration from T0 to return to IDLE is 3 + 4·WORD_W·CLK_DIV cycles (515 for the defaults).
- `done` is asserted in the last of those cycles.
- Exactly 2·WORD_W rising `sclk` edges per frame.
- Minimum `cs_n` high time between frames: 2 cycles (DONE, then the IDLE accept cycle).

## Test plan
- **Reset:** assert `rst_n`=0 for 3 cycles → all outputs at reset values; `sclk`, `cs_n` and `mosi` static.
- **Single frame, defaults:** product_MSB=0xDEADBEEF, product_LSB=0x01234567 through a mux model.
  - Slave sampling `mosi` on `sclk` rising edges recovers 0xDEADBEEF01234567 from exactly 64 edges.
  - `clk_sel`=0 for every MSB-word edge and 1 for every LSB-word edge.
  - `done` pulses 515 cycles after the accept.
- **Back-to-back:** hold `start_valid`=1 → second accept in the IDLE cycle immediately after DONE; `cs_n` high for exactly 2 cycles between frames; both frames decode correctly.
- **Ignored starts:** pulse `start_valid` every 7 cycles during a frame → single `done`, data unchanged, `start_ready`=0 throughout the frame.
- **Reset mid-frame:** drop `rst_n` after the 40th rising edge → outputs at reset values asynchronously, no `done`; next frame 0x0000000100000002 decodes correctly.
- **CLK_DIV=1 edge case:** send 0xFFFFFFFF/0x00000000 → `sclk` period 2 cycles, frame length 131 cycles, 32 ones then 32 zeros received.
